up_mem_responder: RTL and testbench

- Bus target at the far end of the up_controller memory interface.
- Latches an address on ale and returns read data with a mem_re strobe after a programmable number of wait states.
- Performs writes on mem_we and holds the program/data RAM.
- Contains a memory-mapped periodic timer that drives the controller's int input as a level.

---
 rtl/up_mem_responder_if.sv | 36 +++
 rtl/up_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_up_mem_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/up_mem_responder_if.sv
// ---------------------------------------------------------------------------
// up_mem_responder_if
// Memory bus between the up_controller (master) and up_mem_responder (slave).
//
// Signals:
//   ale      master->slave  address latch enable; a read is requested
//   addr     master->slave  bus address
//   mem_we   master->slave  write strobe, one write per asserted cycle
//   wdata    master->slave  write data
//   rdata    slave->master  registered read data
//   mem_re   slave->master  read-data-valid, one-cycle pulse
//   int_req  slave->master  interrupt request level (the controller's "int"
//                           input; "int" itself is a reserved word)
// ---------------------------------------------------------------------------
interface up_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              ale;
    logic [ADDR_W-1:0] addr;
    logic              mem_we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_re;
    logic              int_req;

    modport master (
        output ale, addr, mem_we, wdata,
        input  rdata, mem_re, int_req
    );

    modport slave (
        input  ale, addr, mem_we, wdata,
        output rdata, mem_re, int_req
    );
endinterface

// File: rtl/up_mem_responder.sv
// ---------------------------------------------------------------------------
// up_mem_responder
// Bus target at the far end of the up_controller memory interface. Holds the
// program/data RAM, answers reads after WAIT_STATES extra cycles with a
// one-cycle mem_re pulse, and contains a memory-mapped periodic timer that
// drives the interrupt request level.
//
// Address map:
//   2^ADDR_W-1   TIMER_RELOAD (R/W; a write also loads the running count)
//   2^ADDR_W-2   INT_CTRL  bit0 enable (R/W), bit1 pending (R, write 1 clears)
//   all others   RAM
//
// Ports:
//   clk   system clock, rising edge
//   nRst  synchronous active-low reset
//   bus   slave side of up_mem_if (ale, addr, mem_we, wdata, rdata, mem_re,
//         int_req)
// ---------------------------------------------------------------------------
module up_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic     clk,
    input  logic     nRst,
    up_mem_if.slave  bus
);

    localparam int                RAM_DEPTH = (1 << ADDR_W) - 2;
    localparam logic [ADDR_W-1:0] A_RELOAD  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] A_CTRL    = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]        WAIT_LD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Read FSM state
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_re_q, mem_re_d;

    // Timer / interrupt state
    logic [DATA_W-1:0] reload_q, reload_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              en_q, en_d;
    logic              pend_q, pend_d;
    logic              int_q, int_d;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];

    logic [ADDR_W-1:0] acc_addr;
    logic              is_ram;
    logic              wr_ram;
    logic              wr_reload;
    logic              wr_ctrl;
    logic [DATA_W-1:0] rd_val;
    logic              tick;

    // -----------------------------------------------------------------------
    // Access decode. Both a read being registered and a write use the address
    // on the bus when ale is present this cycle, otherwise the latched one.
    // A read is only ever registered either in the ale cycle (WAIT_STATES=0)
    // or from WAIT, where no ale means the latched address is the right one.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_addr  = bus.ale ? bus.addr : addr_q;
        is_ram    = (acc_addr < A_CTRL);
        wr_ram    = bus.mem_we && is_ram;
        wr_reload = bus.mem_we && (acc_addr == A_RELOAD);
        wr_ctrl   = bus.mem_we && (acc_addr == A_CTRL);

        // Values are taken from current state, so a write committing on the
        // same edge is not seen (read-old).
        rd_val = '0;
        if (acc_addr == A_RELOAD) begin
            rd_val = reload_q;
        end else if (acc_addr == A_CTRL) begin
            rd_val[0] = en_q;
            rd_val[1] = pend_q;
        end else begin
            rd_val = ram_q[acc_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM next state. A new ale always restarts the read, whatever the
    // current state, so the latest ale wins.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;

        if (bus.ale) begin
            addr_d  = bus.addr;
            wcnt_d  = WAIT_LD;
            state_d = (WAIT_LD != 4'd0) ? S_WAIT : S_RESP;
        end else begin
            case (state_q)
                S_WAIT: begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q <= 4'd1) begin
                        state_d = S_RESP;
                    end
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // RESP is only ever entered freshly (RESP without ale leaves it), so
        // every transition into RESP is one response.
        mem_re_d = (state_d == S_RESP);
        rdata_d  = mem_re_d ? rd_val : rdata_q;
    end

    // -----------------------------------------------------------------------
    // Timer and interrupt control. A register write to TIMER_RELOAD overrides
    // the count update of the same cycle; a timer set event overrides a
    // write-1-to-clear of pending in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        en_d     = en_q;
        pend_d   = pend_q;
        tick     = 1'b0;

        if (en_q && (reload_q != '0)) begin
            if (count_q <= DATA_W'(1)) begin
                tick    = 1'b1;
                count_d = reload_q;
            end else begin
                count_d = count_q - DATA_W'(1);
            end
        end

        if (wr_reload) begin
            reload_d = bus.wdata;
            count_d  = bus.wdata;
        end

        if (wr_ctrl) begin
            en_d = bus.wdata[0];
            if (bus.wdata[1]) begin
                pend_d = 1'b0;
            end
        end

        if (tick) begin
            pend_d = 1'b1;
        end

        int_d = pend_d & en_d;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wcnt_q   <= '0;
            rdata_q  <= '0;
            mem_re_q <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            rdata_q  <= rdata_d;
            mem_re_q <= mem_re_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            int_q    <= int_d;
        end
    end

    // RAM contents survive reset; writes are simply ignored while in reset.
    always_ff @(posedge clk) begin
        if (nRst && wr_ram) begin
            ram_q[acc_addr] <= bus.wdata;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.mem_re  = mem_re_q;
    assign bus.int_req = int_q;

endmodule

// File: tb/tb_up_mem_responder.sv
module tb_up_mem_responder;

    logic       clk;
    logic       nRst;
    logic       ale;
    logic [7:0] addr;
    logic       mem_we;
    logic [7:0] wdata;

    int n_chk  = 0;
    int n_fail = 0;

    up_mem_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    up_mem_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();
    up_mem_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

    // All three responders see identical stimulus; they differ only in wait states.
    assign bus0.ale = ale;  assign bus0.addr = addr;  assign bus0.mem_we = mem_we;  assign bus0.wdata = wdata;
    assign bus2.ale = ale;  assign bus2.addr = addr;  assign bus2.mem_we = mem_we;  assign bus2.wdata = wdata;
    assign bus3.ale = ale;  assign bus3.addr = addr;  assign bus3.mem_we = mem_we;  assign bus3.wdata = wdata;

    up_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (.clk(clk), .nRst(nRst), .bus(bus0));
    up_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dut2 (.clk(clk), .nRst(nRst), .bus(bus2));
    up_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) dut3 (.clk(clk), .nRst(nRst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    // Apply inputs for one cycle, then land 1 time unit after the closing edge.
    task automatic drive(input logic a, input logic [7:0] ad, input logic w, input logic [7:0] wd);
        ale = a; addr = ad; mem_we = w; wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nRst = 1'b0;
        ale = 1'b0; addr = 8'h00; mem_we = 1'b0; wdata = 8'h00;
        idle(2);

        // Reset state
        chk("rst_rdata0",  bus0.rdata, 8'h00);
        chk("rst_mem_re0", 8'(bus0.mem_re), 8'h00);
        chk("rst_int0",    8'(bus0.int_req), 8'h00);
        chk("rst_rdata3",  bus3.rdata, 8'h00);
        nRst = 1'b1;
        idle(1);

        // Write 0xA5 to 0x10: ale cycle, then mem_we cycle using latched address
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 8'hA5);
        idle(6);

        // Read 0x10, ale in cycle N
        drive(1'b1, 8'h10, 1'b0, 8'h00);                 // now N+1
        chk("t1_re0_n1",   8'(bus0.mem_re), 8'h01);
        chk("t1_rd0_n1",   bus0.rdata, 8'hA5);
        chk("t2_re2_n1",   8'(bus2.mem_re), 8'h00);
        idle(1);                                          // N+2
        chk("t1_re0_n2",   8'(bus0.mem_re), 8'h00);
        chk("t1_rd0_hold", bus0.rdata, 8'hA5);
        chk("t2_re2_n2",   8'(bus2.mem_re), 8'h00);
        idle(1);                                          // N+3
        chk("t2_re2_n3",   8'(bus2.mem_re), 8'h01);
        chk("t2_rd2_n3",   bus2.rdata, 8'hA5);
        chk("t4_re3_n3",   8'(bus3.mem_re), 8'h00);
        idle(1);                                          // N+4
        chk("t2_re2_n4",   8'(bus2.mem_re), 8'h00);
        chk("t2_rd2_n4",   bus2.rdata, 8'hA5);
        chk("ws3_re3_n4",  8'(bus3.mem_re), 8'h01);
        chk("ws3_rd3_n4",  bus3.rdata, 8'hA5);
        idle(1);                                          // N+5
        chk("ws3_re3_n5",  8'(bus3.mem_re), 8'h00);

        // Fill 0x00..0x03 with 1..4 using ale and mem_we in the same cycle
        for (int k = 0; k < 4; k++) drive(1'b1, 8'(k), 1'b1, 8'(k + 1));
        idle(6);

        // Back-to-back reads on the zero-wait responder
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'(k), 1'b0, 8'h00);
            chk($sformatf("t3_re0_%0d", k), 8'(bus0.mem_re), 8'h01);
            chk($sformatf("t3_rd0_%0d", k), bus0.rdata, 8'(k + 1));
        end
        idle(1);
        chk("t3_re0_end", 8'(bus0.mem_re), 8'h00);

        // Read-old: write 0x5A to 0x10 in the same cycle it is read
        drive(1'b1, 8'h10, 1'b1, 8'h5A);
        chk("rdold_rd0", bus0.rdata, 8'hA5);
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        chk("rdnew_rd0", bus0.rdata, 8'h5A);
        idle(6);

        // Aborted read on WAIT_STATES=3: ale 0x00 in M, ale 0x01 in S=M+2
        drive(1'b1, 8'h00, 1'b0, 8'h00);                 // M+1
        chk("t4_re3_m1", 8'(bus3.mem_re), 8'h00);
        idle(1);                                          // M+2 = S
        chk("t4_re3_m2", 8'(bus3.mem_re), 8'h00);
        drive(1'b1, 8'h01, 1'b0, 8'h00);                 // S+1
        chk("t4_re3_s1", 8'(bus3.mem_re), 8'h00);
        idle(1);                                          // S+2 (old read would pulse here)
        chk("t4_re3_s2", 8'(bus3.mem_re), 8'h00);
        idle(1);                                          // S+3
        chk("t4_re3_s3", 8'(bus3.mem_re), 8'h00);
        idle(1);                                          // S+4
        chk("t4_re3_s4", 8'(bus3.mem_re), 8'h01);
        chk("t4_rd3_s4", bus3.rdata, 8'h02);
        idle(1);                                          // S+5
        chk("t4_re3_s5", 8'(bus3.mem_re), 8'h00);
        idle(6);

        // Timer: reload=5, enable in cycle E
        drive(1'b1, 8'hFF, 1'b1, 8'h05);
        drive(1'b1, 8'hFE, 1'b1, 8'h01);                 // now E+1
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t5_int0_e%0d", i), 8'(bus0.int_req), 8'h00);
            idle(1);
        end
        // E+6
        chk("t5_int0_rise", 8'(bus0.int_req), 8'h01);
        chk("t5_int2_rise", 8'(bus2.int_req), 8'h01);
        drive(1'b1, 8'hFE, 1'b1, 8'h03);                 // clear pending in E+6 -> E+7
        chk("t5_int0_fall", 8'(bus0.int_req), 8'h00);
        idle(3);                                          // E+10
        chk("t5_int0_e10", 8'(bus0.int_req), 8'h00);
        idle(1);                                          // E+11
        chk("t5_int0_rise2", 8'(bus0.int_req), 8'h01);
        drive(1'b1, 8'hFE, 1'b0, 8'h00);                 // read INT_CTRL -> E+12
        chk("t5_ctrl_re", 8'(bus0.mem_re), 8'h01);
        chk("t5_ctrl_rd", bus0.rdata, 8'h03);
        chk("t5_int0_e12", 8'(bus0.int_req), 8'h01);
        drive(1'b1, 8'hFF, 1'b0, 8'h00);                 // read TIMER_RELOAD -> E+13
        chk("t5_reload_rd", bus0.rdata, 8'h05);
        idle(2);                                          // E+15: count reaches 1 here
        drive(1'b1, 8'hFE, 1'b1, 8'h03);                 // clear vs set, same cycle -> E+16
        chk("t5_setwins", 8'(bus0.int_req), 8'h01);

        // Reset while WAIT_STATES=2/3 reads are in WAIT and int is high
        drive(1'b1, 8'h10, 1'b0, 8'h00);                 // W+1
        chk("t6_int_pre", 8'(bus2.int_req), 8'h01);
        nRst = 1'b0;
        idle(1);                                          // W+2
        nRst = 1'b1;
        chk("t6_int0",  8'(bus0.int_req), 8'h00);
        chk("t6_int2",  8'(bus2.int_req), 8'h00);
        chk("t6_rd2",   bus2.rdata, 8'h00);
        chk("t6_rd0",   bus0.rdata, 8'h00);
        chk("t6_re2_w2", 8'(bus2.mem_re), 8'h00);
        idle(1);                                          // W+3
        chk("t6_re2_w3", 8'(bus2.mem_re), 8'h00);
        idle(1);                                          // W+4
        chk("t6_re3_w4", 8'(bus3.mem_re), 8'h00);
        idle(6);
        chk("t6_int_off", 8'(bus0.int_req), 8'h00);
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        chk("t6_re0_after", 8'(bus0.mem_re), 8'h01);
        chk("t6_rd0_after", bus0.rdata, 8'h5A);
        idle(3);
        chk("t6_rd3_after", bus3.rdata, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
